// File: rtl/pin_entry_pkg.sv
// Shared types and constants for the keypad PIN entry verifier.
package pin_entry_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hA;
  localparam logic [DIGIT_W-1:0] KEY_ENTER = 4'hB;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CHECK,
    PASS,
    FAIL
  } state_e;

  // Keypad codes 0..9 are decimal digits.
  function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_entry_verifier_if.sv
// Controller/keypad-facing signal bundle of the PIN entry verifier.
interface pin_entry_verifier_if
  import pin_entry_pkg::*;
#(
  parameter int PIN_DIGITS = 4
);

  localparam int CNT_W = $clog2(PIN_DIGITS + 1);

  logic                          pin_process_init;
  logic                          process_abort;
  logic [DIGIT_W*PIN_DIGITS-1:0] ref_pin;
  logic                          key_valid;
  logic [DIGIT_W-1:0]            key_code;
  logic                          pin_success;
  logic                          pin_fail;
  logic                          timed_out;
  logic                          busy;
  logic [CNT_W-1:0]              digit_count;

  // Controller / keypad side.
  modport master (
    output pin_process_init, process_abort, ref_pin, key_valid, key_code,
    input  pin_success, pin_fail, timed_out, busy, digit_count
  );

  // Verifier side.
  modport slave (
    input  pin_process_init, process_abort, ref_pin, key_valid, key_code,
    output pin_success, pin_fail, timed_out, busy, digit_count
  );

endinterface

// File: rtl/pin_timeout_timer.sv
// Saturating inter-key idle timer; expired is a level at the last count.
module pin_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count up and hold at the last value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/pin_entry_verifier.sv
// Collects keypad digits for one PIN attempt and reports pass/fail.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for pin_process_init; buffer/ref/count held at 0
// COLLECT | accepting digit/clear/enter keys, idle timer running
// CHECK   | one cycle: compare entry against latched reference
// PASS    | one-cycle pin_success pulse
// FAIL    | one-cycle pin_fail pulse (timed_out if cause was timeout)
module pin_entry_verifier
  import pin_entry_pkg::*;
#(
  parameter int PIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic                 clk,
  input logic                 reset,
  pin_entry_verifier_if.slave bus
);

  localparam int CNT_W = $clog2(PIN_DIGITS + 1);
  localparam int BUF_W = DIGIT_W * PIN_DIGITS;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PIN_DIGITS);

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [BUF_W-1:0]   ref_q, ref_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               timeout_q, timeout_d;
  logic               short_q, short_d;

  logic               key_accept;
  logic               timer_clear;
  logic               timer_en;
  logic               timer_expired;

  pin_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  // Next-state, entry buffer and timer control.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    ref_d       = ref_q;
    count_d     = count_q;
    timeout_d   = timeout_q;
    short_d     = short_q;
    timer_clear = 1'b1;
    timer_en    = 1'b0;
    // Codes 0xC-0xF are not "accepted": they neither act nor restart the timer.
    key_accept  = bus.key_valid && (bus.key_code <= KEY_ENTER);

    case (state_q)
      IDLE: begin
        if (bus.pin_process_init && !bus.process_abort) begin
          state_d = COLLECT;
          ref_d   = bus.ref_pin;
          buf_d   = '0;
          count_d = '0;
        end
      end
      COLLECT: begin
        timer_clear = 1'b0;
        timer_en    = 1'b1;
        if (bus.process_abort) begin
          state_d = IDLE;
        end else if (key_accept) begin
          timer_clear = 1'b1;
          if (is_digit(bus.key_code)) begin
            if (count_q < FULL) begin
              buf_d[DIGIT_W*int'(count_q) +: DIGIT_W] = bus.key_code;
              count_d = count_q + 1'b1;
            end
          end else if (bus.key_code == KEY_CLEAR) begin
            buf_d   = '0;
            count_d = '0;
          end else begin
            state_d = CHECK;
            short_d = (count_q != FULL);
          end
        end else if (timer_expired) begin
          state_d   = FAIL;
          timeout_d = 1'b1;
        end
      end
      CHECK: begin
        if (bus.process_abort)                state_d = IDLE;
        else if (!short_q && buf_q == ref_q)  state_d = PASS;
        else                                  state_d = FAIL;
      end
      PASS, FAIL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Leave no PIN residue behind once the attempt ends.
    if (state_d == IDLE) begin
      buf_d     = '0;
      ref_d     = '0;
      count_d   = '0;
      timeout_d = 1'b0;
      short_d   = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      ref_q     <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      ref_q     <= ref_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      short_q   <= short_d;
    end
  end

  assign bus.pin_success = (state_q == PASS);
  assign bus.pin_fail    = (state_q == FAIL);
  assign bus.timed_out   = (state_q == FAIL) && timeout_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.digit_count = count_q;

endmodule
